rf_wb_sched: RTL and testbench

RF_WB_SCHED -- requirements
Module: rf_wb_sched

---
 rtl/rf_wb_sched_pkg.sv | 15 +
 rtl/rf_wb_sched_rr_arb2.sv | 47 ++++
 rtl/rf_wb_sched.sv | 105 ++++++++++
 tb/tb_rf_wb_sched.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_sched_pkg.sv
// Shared core definitions for the writeback scheduler: data/register sizing
// and the writeback requester enumeration.
package rf_wb_sched_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NREG      = 32;
  localparam int unsigned REG_IDX_W = $clog2(NREG);

  // Writeback requesters; the value doubles as the arbiter request/grant bit.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

endpackage

// File: rtl/rf_wb_sched_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i[1:0]    : requests, bit REQ_ALU / bit REQ_LSU
//   gnt_o[1:0]    : combinational grants, at most one set, zero in reset
// A lone request is granted directly; on a conflict the pointer's requester
// wins and the pointer flips. The pointer holds when there is no conflict.
module rr_arb2
  import rf_wb_sched_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  req_e ptr_q;
  req_e ptr_d;

  // Grant selection and pointer update
  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (rst_ni) begin
      if (&req_i) begin
        if (ptr_q == REQ_ALU) begin
          gnt_o = 2'b01;
          ptr_d = REQ_LSU;
        end else begin
          gnt_o = 2'b10;
          ptr_d = REQ_ALU;
        end
      end else begin
        gnt_o = req_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= REQ_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// Register-file writeback scheduler with issue scoreboard.
// Ports:
//   clk_i, rst_ni                     : clock, asynchronous active-low reset
//   issue_*_i / issue_stall_o         : decode issue request and hazard stall
//   alu_*_i / alu_ready_o             : ALU writeback valid/ready channel
//   lsu_*_i / lsu_ready_o             : LSU writeback valid/ready channel
//   rf_we_o, rf_rd_o, rf_din_o        : registered register-file write port
//   busy_o                            : per-register pending-write scoreboard
module rf_wb_sched #(
  parameter int unsigned XLEN = rf_wb_sched_pkg::XLEN,
  parameter int unsigned NREG = rf_wb_sched_pkg::NREG
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    issue_valid_i,
  input  logic [$clog2(NREG)-1:0] issue_rs1_i,
  input  logic [$clog2(NREG)-1:0] issue_rs2_i,
  input  logic [$clog2(NREG)-1:0] issue_rd_i,
  input  logic                    issue_we_i,
  output logic                    issue_stall_o,
  input  logic                    alu_valid_i,
  input  logic [$clog2(NREG)-1:0] alu_rd_i,
  input  logic [XLEN-1:0]         alu_data_i,
  output logic                    alu_ready_o,
  input  logic                    lsu_valid_i,
  input  logic [$clog2(NREG)-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]         lsu_data_i,
  output logic                    lsu_ready_o,
  output logic                    rf_we_o,
  output logic [$clog2(NREG)-1:0] rf_rd_o,
  output logic [XLEN-1:0]         rf_din_o,
  output logic [NREG-1:0]         busy_o
);

  import rf_wb_sched_pkg::*;

  localparam int unsigned IDXW = $clog2(NREG);

  logic [1:0]      gnt;
  logic            wb_acc;
  logic [IDXW-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            issue_acc;

  logic [NREG-1:0] busy_q, busy_d;
  logic            rf_we_q, rf_we_d;
  logic [IDXW-1:0] rf_rd_q;
  logic [XLEN-1:0] rf_din_q;

  rr_arb2 u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  ({lsu_valid_i, alu_valid_i}),
    .gnt_o  (gnt)
  );

  assign alu_ready_o = gnt[REQ_ALU];
  assign lsu_ready_o = gnt[REQ_LSU];

  // Mux the winning writeback onto the shared port
  assign wb_acc  = |gnt;
  assign wb_rd   = gnt[REQ_LSU] ? lsu_rd_i   : alu_rd_i;
  assign wb_data = gnt[REQ_LSU] ? lsu_data_i : alu_data_i;
  assign rf_we_d = wb_acc && (wb_rd != '0);

  // Hazard check uses registered state only: no same-cycle writeback bypass
  assign issue_stall_o = rst_ni && issue_valid_i &&
                         (busy_q[issue_rs1_i] || busy_q[issue_rs2_i] ||
                          (issue_we_i && busy_q[issue_rd_i]));
  assign issue_acc     = issue_valid_i && !issue_stall_o;

  // Scoreboard update; the issue set is applied after the clear so it wins
  always_comb begin
    busy_d = busy_q;
    if (wb_acc) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (issue_acc && issue_we_i && (issue_rd_i != '0)) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q   <= '0;
      rf_we_q  <= 1'b0;
      rf_rd_q  <= '0;
      rf_din_q <= '0;
    end else begin
      busy_q  <= busy_d;
      rf_we_q <= rf_we_d;
      if (wb_acc) begin
        rf_rd_q  <= wb_rd;
        rf_din_q <= wb_data;
      end
    end
  end

  assign busy_o   = busy_q;
  assign rf_we_o  = rf_we_q;
  assign rf_rd_o  = rf_rd_q;
  assign rf_din_o = rf_din_q;

endmodule

// File: tb/tb_rf_wb_sched.sv
// Bench for rf_wb_sched: directed vector table, reset-in-flight sequence and
// constrained-random traffic, all checked against a behavioural model.
module tb_rf_wb_sched;

  localparam int NREG = 32;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic [4:0]  issue_rs1_i = '0, issue_rs2_i = '0, issue_rd_i = '0;
  logic        issue_we_i = 1'b0;
  logic        issue_stall_o;
  logic        alu_valid_i = 1'b0;
  logic [4:0]  alu_rd_i = '0;
  logic [31:0] alu_data_i = '0;
  logic        alu_ready_o;
  logic        lsu_valid_i = 1'b0;
  logic [4:0]  lsu_rd_i = '0;
  logic [31:0] lsu_data_i = '0;
  logic        lsu_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_din_o;
  logic [31:0] busy_o;

  rf_wb_sched dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_rs1_i(issue_rs1_i),
    .issue_rs2_i(issue_rs2_i), .issue_rd_i(issue_rd_i),
    .issue_we_i(issue_we_i), .issue_stall_o(issue_stall_o),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .alu_ready_o(alu_ready_o),
    .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .lsu_ready_o(lsu_ready_o),
    .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_din_o(rf_din_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: set of registers with pending writes, whose turn a
  // tie goes to, and the write the port must show after the edge.
  bit          mbusy[NREG];
  int          turn;          // 0: ALU wins next tie, 1: LSU wins next tie
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_din;
  bit          e_ar, e_lr, e_st;

  function automatic bit pending(input logic [4:0] r);
    return (r != 0) && mbusy[r];
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] v = '0;
    for (int i = 0; i < NREG; i++) v[i] = mbusy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mbusy[i] = 0;
    turn = 0; m_we = 0; m_rd = '0; m_din = '0;
  endtask

  // Observed values of the last step, for table comparisons
  logic        o_ar, o_lr, o_st, o_we;
  logic [4:0]  o_rd;
  logic [31:0] o_din, o_busy;

  // Called just after a falling edge with inputs already driven; returns
  // at the next falling edge.
  task automatic step();
    bit acc;
    logic [4:0] wrd;
    #1;
    e_ar = alu_valid_i && (!lsu_valid_i || turn == 0);
    e_lr = lsu_valid_i && (!alu_valid_i || turn == 1);
    e_st = issue_valid_i && (pending(issue_rs1_i) || pending(issue_rs2_i) ||
                             (issue_we_i && pending(issue_rd_i)));
    o_ar = alu_ready_o; o_lr = lsu_ready_o; o_st = issue_stall_o;
    chk("alu_ready", 32'(alu_ready_o), 32'(e_ar));
    chk("lsu_ready", 32'(lsu_ready_o), 32'(e_lr));
    chk("issue_stall", 32'(issue_stall_o), 32'(e_st));
    if (alu_valid_i && lsu_valid_i) turn = 1 - turn;
    acc = e_ar || e_lr;
    wrd = e_lr ? lsu_rd_i : alu_rd_i;
    m_we = acc && (wrd != 0);
    if (acc) begin
      m_rd = wrd;
      m_din = e_lr ? lsu_data_i : alu_data_i;
      mbusy[wrd] = 0;
    end
    if (issue_valid_i && !e_st && issue_we_i && issue_rd_i != 0) mbusy[issue_rd_i] = 1;
    @(posedge clk_i);
    #1;
    o_we = rf_we_o; o_rd = rf_rd_o; o_din = rf_din_o; o_busy = busy_o;
    chk("rf_we", 32'(rf_we_o), 32'(m_we));
    if (m_we) begin
      chk("rf_rd", 32'(rf_rd_o), 32'(m_rd));
      chk("rf_din", rf_din_o, m_din);
    end
    chk("busy", busy_o, model_busy());
    @(negedge clk_i);
  endtask

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic lv; logic [4:0] lrd; logic [31:0] ld;
    logic iv; logic [4:0] rs1, rs2, rd; logic we;
    logic x_ar, x_lr, x_st, x_we; logic [4:0] x_rd; logic [31:0] x_din, x_busy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Directed vectors applied from reset, each with hand-derived results
    tbl[0]  = '{1,5,32'h1234, 0,0,0,       0,0,0,0,0, 1,0,0,1,5,32'h1234,32'h0};
    tbl[1]  = '{1,3,32'hA,    1,4,32'hB,   0,0,0,0,0, 1,0,0,1,3,32'hA,   32'h0};
    tbl[2]  = '{1,3,32'hA,    1,4,32'hB,   0,0,0,0,0, 0,1,0,1,4,32'hB,   32'h0};
    tbl[3]  = '{1,3,32'hA,    0,0,0,       0,0,0,0,0, 1,0,0,1,3,32'hA,   32'h0};
    tbl[4]  = '{0,0,0,        0,0,0,       1,0,0,7,1, 0,0,0,0,0,0,       32'h80};
    tbl[5]  = '{0,0,0,        0,0,0,       1,7,0,8,1, 0,0,1,0,0,0,       32'h80};
    tbl[6]  = '{0,0,0,        1,7,32'h77,  1,7,0,8,1, 0,1,1,1,7,32'h77,  32'h0};
    tbl[7]  = '{0,0,0,        0,0,0,       1,7,0,8,1, 0,0,0,0,0,0,       32'h100};
    tbl[8]  = '{1,9,32'h99,   0,0,0,       1,0,0,9,1, 1,0,0,1,9,32'h99,  32'h300};
    tbl[9]  = '{0,0,0,        0,0,0,       1,0,0,0,1, 0,0,0,0,0,0,       32'h300};
    tbl[10] = '{1,0,32'h55,   0,0,0,       1,0,0,0,0, 1,0,0,0,0,0,       32'h300};
    tbl[11] = '{0,0,0,        1,8,32'h88,  0,0,0,0,0, 0,1,0,1,8,32'h88,  32'h200};
    tbl[12] = '{0,0,0,        0,0,0,       1,0,0,9,1, 0,0,1,0,0,0,       32'h200};
    tbl[13] = '{0,0,0,        0,0,0,       0,0,0,9,1, 0,0,0,0,0,0,       32'h200};

    // Reset with requests present: everything quiet
    model_reset();
    alu_valid_i = 1; lsu_valid_i = 1; issue_valid_i = 1;
    #12;
    chk("rst_alu_ready", 32'(alu_ready_o), 32'h0);
    chk("rst_lsu_ready", 32'(lsu_ready_o), 32'h0);
    chk("rst_stall", 32'(issue_stall_o), 32'h0);
    chk("rst_rf_we", 32'(rf_we_o), 32'h0);
    chk("rst_busy", busy_o, 32'h0);
    alu_valid_i = 0; lsu_valid_i = 0; issue_valid_i = 0;
    @(negedge clk_i);
    rst_ni = 1;

    for (int i = 0; i < 14; i++) begin
      alu_valid_i = tbl[i].av; alu_rd_i = tbl[i].ard; alu_data_i = tbl[i].ad;
      lsu_valid_i = tbl[i].lv; lsu_rd_i = tbl[i].lrd; lsu_data_i = tbl[i].ld;
      issue_valid_i = tbl[i].iv; issue_rs1_i = tbl[i].rs1;
      issue_rs2_i = tbl[i].rs2; issue_rd_i = tbl[i].rd; issue_we_i = tbl[i].we;
      step();
      chk($sformatf("vec%0d_alu_ready", i), 32'(o_ar), 32'(tbl[i].x_ar));
      chk($sformatf("vec%0d_lsu_ready", i), 32'(o_lr), 32'(tbl[i].x_lr));
      chk($sformatf("vec%0d_stall", i), 32'(o_st), 32'(tbl[i].x_st));
      chk($sformatf("vec%0d_rf_we", i), 32'(o_we), 32'(tbl[i].x_we));
      if (tbl[i].x_we) begin
        chk($sformatf("vec%0d_rf_rd", i), 32'(o_rd), 32'(tbl[i].x_rd));
        chk($sformatf("vec%0d_rf_din", i), o_din, tbl[i].x_din);
      end
      chk($sformatf("vec%0d_busy", i), o_busy, tbl[i].x_busy);
    end

    // Reset while a write is on the port and a transfer is pending
    alu_valid_i = 0; lsu_valid_i = 0; issue_we_i = 1;
    issue_valid_i = 1; issue_rs1_i = 0; issue_rs2_i = 0;
    issue_rd_i = 7; step();
    issue_rd_i = 11; step();
    chk("mid_busy_setup", busy_o, 32'h0000_0A80);
    issue_valid_i = 0;
    alu_valid_i = 1; alu_rd_i = 3; alu_data_i = 32'hC; step();
    chk("mid_rf_we_before", 32'(rf_we_o), 32'h1);
    alu_rd_i = 5; alu_data_i = 32'hDEAD; lsu_valid_i = 1; lsu_rd_i = 11;
    issue_valid_i = 1; issue_rs1_i = 7;
    #1 rst_ni = 0;
    #1;
    chk("mid_rst_busy", busy_o, 32'h0);
    chk("mid_rst_rf_we", 32'(rf_we_o), 32'h0);
    chk("mid_rst_alu_ready", 32'(alu_ready_o), 32'h0);
    chk("mid_rst_lsu_ready", 32'(lsu_ready_o), 32'h0);
    chk("mid_rst_stall", 32'(issue_stall_o), 32'h0);
    @(negedge clk_i);
    alu_valid_i = 0; lsu_valid_i = 0; issue_valid_i = 0;
    model_reset();
    rst_ni = 1;
    step();
    chk("post_rst_rf_we", 32'(o_we), 32'h0);
    chk("post_rst_busy", o_busy, 32'h0);

    // Random traffic; unaccepted writebacks hold their payload
    for (int n = 0; n < 400; n++) begin
      if (!(alu_valid_i && !e_ar) || n == 0) begin
        alu_valid_i = ($urandom_range(0, 2) != 0);
        alu_rd_i = 5'($urandom_range(0, 7));
        alu_data_i = $urandom;
      end
      if (!(lsu_valid_i && !e_lr) || n == 0) begin
        lsu_valid_i = ($urandom_range(0, 2) != 0);
        lsu_rd_i = 5'($urandom_range(0, 7));
        lsu_data_i = $urandom;
      end
      issue_valid_i = ($urandom_range(0, 3) != 0);
      issue_rs1_i = 5'($urandom_range(0, 7));
      issue_rs2_i = 5'($urandom_range(0, 7));
      issue_rd_i = 5'($urandom_range(0, 7));
      issue_we_i = 1'($urandom_range(0, 1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
